// File: rtl/piezo_arbiter_if.sv
// ---------------------------------------------------------------------------
// piezo_arbiter_if
// Bundles the request/tone inputs and status outputs of the piezo arbiter.
//   master : watch top level (or bench). Drives ALARM_REQ, ALARM_TONE,
//            CHIME_REQ, CLICK_REQ and MUTE. Observes PIEZO, GRANT, BUSY
//            and CHIME_PEND.
//   slave  : piezo_arbiter. Mirror image of master.
// Signals:
//   ALARM_REQ   level, alarm active
//   ALARM_TONE  melody square wave
//   CHIME_REQ   one-cycle pulse at hour rollover
//   CLICK_REQ   one-cycle pulse per debounced button press
//   MUTE        level, blocks new chime/click requests
//   PIEZO       registered buzzer drive
//   GRANT       00 idle, 01 click, 10 chime, 11 alarm
//   BUSY        GRANT != 00
//   CHIME_PEND  a deferred chime is waiting
// ---------------------------------------------------------------------------
interface piezo_arbiter_if;
  logic       ALARM_REQ;
  logic       ALARM_TONE;
  logic       CHIME_REQ;
  logic       CLICK_REQ;
  logic       MUTE;
  logic       PIEZO;
  logic [1:0] GRANT;
  logic       BUSY;
  logic       CHIME_PEND;

  modport master (
    output ALARM_REQ, ALARM_TONE, CHIME_REQ, CLICK_REQ, MUTE,
    input  PIEZO, GRANT, BUSY, CHIME_PEND
  );

  modport slave (
    input  ALARM_REQ, ALARM_TONE, CHIME_REQ, CLICK_REQ, MUTE,
    output PIEZO, GRANT, BUSY, CHIME_PEND
  );
endinterface

// File: rtl/piezo_arbiter.sv
// ---------------------------------------------------------------------------
// piezo_arbiter
// Shares the PIEZO pin between the alarm melody, the hourly chime and the
// key-click beep with fixed priority alarm > chime > click. The chime and
// click tones are generated here; the alarm tone is passed through with one
// register of delay.
// Ports:
//   CLK     system clock
//   RESETN  synchronous active-low reset
//   bus     piezo_arbiter_if.slave (requests in, PIEZO/GRANT/BUSY/CHIME_PEND out)
// Parameters:
//   CLK_HZ     clock frequency; one ms tick every CLK_HZ/1000 clocks
//   CLICK_MS   click length in ms
//   CLICK_DIV  click half-period in clocks
//   CHIME_MS   length of each chime phase (beep, gap, beep) in ms
//   CHIME_DIV  chime half-period in clocks
// ---------------------------------------------------------------------------
module piezo_arbiter #(
  parameter int CLK_HZ    = 1000000,
  parameter int CLICK_MS  = 20,
  parameter int CLICK_DIV = 250,
  parameter int CHIME_MS  = 100,
  parameter int CHIME_DIV = 500
) (
  input  logic           CLK,
  input  logic           RESETN,
  piezo_arbiter_if.slave bus
);

  // State code doubles as the GRANT encoding.
  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_CLICK = 2'b01;
  localparam logic [1:0] ST_CHIME = 2'b10;
  localparam logic [1:0] ST_ALARM = 2'b11;

  localparam logic [1:0] PH_BEEP1 = 2'd0;
  localparam logic [1:0] PH_GAP   = 2'd1;
  localparam logic [1:0] PH_BEEP2 = 2'd2;

  localparam int PRE_TC  = CLK_HZ / 1000 - 1;
  localparam int PRE_W   = (PRE_TC > 0) ? $clog2(PRE_TC + 1) : 1;
  localparam int MS_MAX  = (CLICK_MS > CHIME_MS) ? CLICK_MS : CHIME_MS;
  localparam int MS_W    = (MS_MAX > 1) ? $clog2(MS_MAX) : 1;
  localparam int DIV_MAX = (CLICK_DIV > CHIME_DIV) ? CLICK_DIV : CHIME_DIV;
  localparam int DIV_W   = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;

  logic [1:0]       state_q, state_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [MS_W-1:0]  ms_q, ms_d;
  logic [1:0]       phase_q, phase_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             piezo_q, piezo_d;
  logic             pend_q, pend_d;
  logic             busy_q;

  logic             ms_tick;
  logic             click_done;
  logic             phase_done;
  logic [DIV_W-1:0] div_tc;
  logic             div_wrap;
  logic             chime_new;

  assign ms_tick    = (pre_q == PRE_W'(PRE_TC));
  assign click_done = ms_tick && (ms_q == MS_W'(CLICK_MS - 1));
  assign phase_done = ms_tick && (ms_q == MS_W'(CHIME_MS - 1));
  assign div_tc     = (state_q == ST_CLICK) ? DIV_W'(CLICK_DIV - 1) : DIV_W'(CHIME_DIV - 1);
  assign div_wrap   = (div_q == div_tc);
  assign chime_new  = bus.CHIME_REQ && !bus.MUTE;

  // Next-state selection.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.ALARM_REQ)                state_d = ST_ALARM;
        else if (pend_q || chime_new)     state_d = ST_CHIME;
        else if (bus.CLICK_REQ && !bus.MUTE) state_d = ST_CLICK;
      end
      ST_CLICK: begin
        if (bus.ALARM_REQ)   state_d = ST_ALARM;
        else if (click_done) state_d = ST_IDLE;
      end
      ST_CHIME: begin
        if (bus.ALARM_REQ)                          state_d = ST_ALARM;
        else if (phase_done && phase_q == PH_BEEP2) state_d = ST_IDLE;
      end
      default: begin
        if (!bus.ALARM_REQ) state_d = ST_IDLE;
      end
    endcase
  end

  // Pending chime: a chime accepted outside IDLE is remembered (one deep);
  // in IDLE the flag is only consumed, never set, so a chime pulse that
  // loses to the alarm in the same cycle is dropped.
  always_comb begin
    pend_d = pend_q;
    if (state_q == ST_IDLE) begin
      if (state_d == ST_CHIME) pend_d = 1'b0;
    end else if (chime_new) begin
      pend_d = 1'b1;
    end
  end

  // Timing counters and PIEZO drive.
  always_comb begin
    pre_d   = pre_q;
    ms_d    = ms_q;
    phase_d = phase_q;
    div_d   = div_q;
    piezo_d = piezo_q;
    if (state_d != state_q) begin
      // Any state entry restarts everything so durations are exact.
      pre_d   = '0;
      ms_d    = '0;
      phase_d = PH_BEEP1;
      div_d   = '0;
      piezo_d = (state_d == ST_ALARM) ? bus.ALARM_TONE : 1'b0;
    end else begin
      case (state_q)
        ST_CLICK: begin
          pre_d = ms_tick ? '0 : pre_q + PRE_W'(1);
          if (ms_tick) ms_d = ms_q + MS_W'(1);
          div_d = div_wrap ? '0 : div_q + DIV_W'(1);
          if (div_wrap) piezo_d = ~piezo_q;
        end
        ST_CHIME: begin
          pre_d = ms_tick ? '0 : pre_q + PRE_W'(1);
          if (phase_done) begin
            // Phase boundary: tone restarts low in the next phase.
            ms_d    = '0;
            phase_d = phase_q + 2'd1;
            div_d   = '0;
            piezo_d = 1'b0;
          end else begin
            if (ms_tick) ms_d = ms_q + MS_W'(1);
            if (phase_q == PH_GAP) begin
              div_d   = '0;
              piezo_d = 1'b0;
            end else begin
              div_d = div_wrap ? '0 : div_q + DIV_W'(1);
              if (div_wrap) piezo_d = ~piezo_q;
            end
          end
        end
        ST_ALARM: begin
          pre_d   = '0;
          ms_d    = '0;
          div_d   = '0;
          piezo_d = bus.ALARM_TONE;
        end
        default: begin
          pre_d   = '0;
          ms_d    = '0;
          phase_d = PH_BEEP1;
          div_d   = '0;
          piezo_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      state_q <= ST_IDLE;
      pre_q   <= '0;
      ms_q    <= '0;
      phase_q <= PH_BEEP1;
      div_q   <= '0;
      piezo_q <= 1'b0;
      pend_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      ms_q    <= ms_d;
      phase_q <= phase_d;
      div_q   <= div_d;
      piezo_q <= piezo_d;
      pend_q  <= pend_d;
      busy_q  <= (state_d != ST_IDLE);
    end
  end

  assign bus.PIEZO      = piezo_q;
  assign bus.GRANT      = state_q;
  assign bus.BUSY       = busy_q;
  assign bus.CHIME_PEND = pend_q;

endmodule

// File: tb/tb_piezo_arbiter.sv
// ---------------------------------------------------------------------------
// tb_piezo_arbiter
// Scoreboard bench: before every clock edge a behavioural model predicts the
// outputs {PIEZO, GRANT, BUSY, CHIME_PEND} that must appear after the edge
// and pushes them to a queue; #1 after the edge the entry is popped and
// compared with the DUT. Scaled-down timing keeps the run short.
// ---------------------------------------------------------------------------
module tb_piezo_arbiter;
  localparam int CLK_HZ    = 10000;
  localparam int CLICK_MS  = 4;
  localparam int CLICK_DIV = 3;
  localparam int CHIME_MS  = 3;
  localparam int CHIME_DIV = 4;

  localparam int MS_CYC    = CLK_HZ / 1000;
  localparam int CLICK_LEN = CLICK_MS * MS_CYC;
  localparam int PH_LEN    = CHIME_MS * MS_CYC;

  logic CLK    = 1'b0;
  logic RESETN = 1'b0;

  piezo_arbiter_if bus();

  piezo_arbiter #(
    .CLK_HZ    (CLK_HZ),
    .CLICK_MS  (CLICK_MS),
    .CLICK_DIV (CLICK_DIV),
    .CHIME_MS  (CHIME_MS),
    .CHIME_DIV (CHIME_DIV)
  ) dut (
    .CLK    (CLK),
    .RESETN (RESETN),
    .bus    (bus)
  );

  always #5 CLK = ~CLK;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [4:0] exp_q[$];
  string      scen = "reset";

  // Model state: m_t is the index of the current cycle within the state.
  int m_state = 0;
  int m_t     = 0;
  bit m_pend  = 1'b0;
  bit m_piezo = 1'b0;

  task automatic check_eq(input string tag, input logic [4:0] got, input logic [4:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: {piezo,grant,busy,pend} got %b expected %b", tag, $time, got, exp);
    end
  endtask

  task automatic model_step();
    int  ns;
    bit  np;
    int  nt;
    int  ph;
    bit  chime_ok;
    if (!RESETN) begin
      m_state = 0;
      m_t     = 0;
      m_pend  = 1'b0;
      m_piezo = 1'b0;
    end else begin
      ns = m_state;
      np = m_pend;
      chime_ok = bus.CHIME_REQ && !bus.MUTE;
      case (m_state)
        0: begin
          if (bus.ALARM_REQ) ns = 3;
          else if (m_pend || chime_ok) begin ns = 2; np = 1'b0; end
          else if (bus.CLICK_REQ && !bus.MUTE) ns = 1;
        end
        1: begin
          if (bus.ALARM_REQ) ns = 3;
          else if (m_t == CLICK_LEN - 1) ns = 0;
        end
        2: begin
          if (bus.ALARM_REQ) ns = 3;
          else if (m_t == 3 * PH_LEN - 1) ns = 0;
        end
        default: if (!bus.ALARM_REQ) ns = 0;
      endcase
      if (m_state != 0 && chime_ok) np = 1'b1;
      nt = (ns != m_state) ? 0 : m_t + 1;
      case (ns)
        1: m_piezo = ((nt / CLICK_DIV) % 2) == 1;
        2: begin
          ph = nt / PH_LEN;
          m_piezo = (ph == 1) ? 1'b0 : (((nt % PH_LEN) / CHIME_DIV) % 2) == 1;
        end
        3: m_piezo = bus.ALARM_TONE;
        default: m_piezo = 1'b0;
      endcase
      m_state = ns;
      m_t     = nt;
      m_pend  = np;
    end
    exp_q.push_back({m_piezo, 2'(m_state), (m_state != 0), m_pend});
  endtask

  task automatic tick();
    logic [4:0] exp;
    model_step();
    @(posedge CLK);
    #1;
    exp = exp_q.pop_front();
    check_eq(scen, {bus.PIEZO, bus.GRANT, bus.BUSY, bus.CHIME_PEND}, exp);
    // Requests are one-cycle pulses; tone is a free-running random wave.
    bus.CHIME_REQ  = 1'b0;
    bus.CLICK_REQ  = 1'b0;
    bus.ALARM_TONE = 1'($urandom_range(0, 1));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic done(input string name);
    $display("[%0t] %s: %0d checks so far", $time, name, n_checks);
  endtask

  initial begin
    bus.ALARM_REQ  = 1'b0;
    bus.ALARM_TONE = 1'b0;
    bus.CHIME_REQ  = 1'b0;
    bus.CLICK_REQ  = 1'b0;
    bus.MUTE       = 1'b0;
    RESETN         = 1'b0;
    run(3);
    RESETN = 1'b1;
    run(5);
    done("reset");

    scen = "click";
    bus.CLICK_REQ = 1'b1;
    run(CLICK_LEN + 10);
    done(scen);

    scen = "chime";
    bus.CHIME_REQ = 1'b1;
    run(3 * PH_LEN + 10);
    done(scen);

    scen = "chime_preempt";
    bus.CHIME_REQ = 1'b1;
    run(10);
    bus.ALARM_REQ = 1'b1;
    run(20);
    bus.ALARM_REQ = 1'b0;
    run(3 * PH_LEN + 10);
    done(scen);

    scen = "pend_in_alarm";
    bus.ALARM_REQ = 1'b1;
    run(5);
    bus.CHIME_REQ = 1'b1;
    run(5);
    bus.CHIME_REQ = 1'b1;
    run(3);
    bus.ALARM_REQ = 1'b0;
    run(3 * PH_LEN + 10);
    done(scen);

    scen = "chime_click_same";
    bus.CHIME_REQ = 1'b1;
    bus.CLICK_REQ = 1'b1;
    run(3 * PH_LEN + 20);
    done(scen);

    scen = "mute_both";
    bus.MUTE      = 1'b1;
    bus.CHIME_REQ = 1'b1;
    bus.CLICK_REQ = 1'b1;
    run(10);
    bus.MUTE = 1'b0;
    done(scen);

    scen = "click_then_pend";
    bus.CLICK_REQ = 1'b1;
    run(10);
    bus.CHIME_REQ = 1'b1;
    tick();
    bus.CLICK_REQ = 1'b1;
    run(CLICK_LEN + 3 * PH_LEN + 10);
    done(scen);

    scen = "pend_kept_muted";
    bus.ALARM_REQ = 1'b1;
    run(4);
    bus.CHIME_REQ = 1'b1;
    run(3);
    bus.MUTE = 1'b1;
    run(3);
    bus.ALARM_REQ = 1'b0;
    run(3 * PH_LEN + 10);
    bus.MUTE = 1'b0;
    done(scen);

    scen = "reset_mid_click";
    bus.CLICK_REQ = 1'b1;
    run(10);
    RESETN = 1'b0;
    tick();
    RESETN = 1'b1;
    run(3);
    done(scen);

    scen = "reset_mid_alarm";
    bus.ALARM_REQ = 1'b1;
    run(5);
    bus.CHIME_REQ = 1'b1;
    tick();
    RESETN = 1'b0;
    tick();
    RESETN = 1'b1;
    run(5);
    bus.ALARM_REQ = 1'b0;
    run(5);
    done(scen);

    scen = "random";
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 59) == 0) bus.ALARM_REQ = ~bus.ALARM_REQ;
      if ($urandom_range(0, 79) == 0) bus.MUTE = ~bus.MUTE;
      bus.CHIME_REQ = ($urandom_range(0, 49) == 0);
      bus.CLICK_REQ = ($urandom_range(0, 19) == 0);
      RESETN = ($urandom_range(0, 399) != 0);
      tick();
    end
    RESETN = 1'b1;
    done(scen);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
